// File: rtl/time_set_input.sv
// Set-time front end: synchronizes and debounces the mode switch and hour
// buttons, then turns button presses into inc/dec strobes with auto-repeat.
module time_set_input #(
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int HOLD_CYC     = 25000000,
   parameter int REPEAT_CYC   = 5000000,
   parameter int CNT_W        = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   input  logic button1,
   input  logic button2,
   output logic set_mode,
   output logic btn1_level,
   output logic btn2_level,
   output logic inc_pulse,
   output logic dec_pulse
);

   localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYC - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

   // bit 0 = sw, bit 1 = button1, bit 2 = button2
   logic [2:0]       raw;
   logic [2:0]       s1_q, s2_q;
   logic [2:0]       lvl_q, lvl_d;
   logic [CNT_W-1:0] dbc_q [3];
   logic [CNT_W-1:0] dbc_d [3];
   logic [2:1]       prev_q;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             inc_q, inc_d;
   logic             dec_q, dec_d;

   logic             set_lvl, press1, press2;
   logic             held, other, hold_ok;
   logic [CNT_W-1:0] tc;

   assign raw = {button2, button1, sw};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         lvl_d[i] = lvl_q[i];
         dbc_d[i] = '0;
         if (s2_q[i] != lvl_q[i]) begin
            if (dbc_q[i] == DB_TC) lvl_d[i] = s2_q[i];
            else dbc_d[i] = dbc_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         lvl_q  <= '0;
         prev_q <= '0;
         for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
      end else begin
         s1_q   <= raw;
         s2_q   <= s1_q;
         lvl_q  <= lvl_d;
         prev_q <= lvl_q[2:1];
         for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
      end
   end

   assign set_lvl = lvl_q[0];
   assign press1  = lvl_q[1] & ~prev_q[1];
   assign press2  = lvl_q[2] & ~prev_q[2];
   assign held    = dir_q ? lvl_q[2] : lvl_q[1];
   assign other   = dir_q ? lvl_q[1] : lvl_q[2];
   assign hold_ok = set_lvl & held & ~other;
   assign tc      = (state_q == DELAY) ? HOLD_TC : REP_TC;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (set_lvl) begin
               if (press1 & ~lvl_q[2]) state_d = DELAY;
               else if (press2 & ~lvl_q[1]) state_d = DELAY;
               else if (press1 | press2) state_d = LOCK;
            end
         end
         DELAY, REPEAT: begin
            if (!set_lvl || !held) state_d = IDLE;
            else if (other) state_d = LOCK;
            else if (state_q == DELAY && cnt_q == HOLD_TC) state_d = REPEAT;
         end
         LOCK: begin
            if (!set_lvl || (!lvl_q[1] && !lvl_q[2])) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // release, mode exit and the other button all override a terminal count
   always_comb begin
      cnt_d = '0;
      dir_d = dir_q;
      inc_d = 1'b0;
      dec_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (set_lvl && press1 && !lvl_q[2]) begin
               inc_d = 1'b1;
               dir_d = 1'b0;
            end else if (set_lvl && press2 && !lvl_q[1]) begin
               dec_d = 1'b1;
               dir_d = 1'b1;
            end
         end
         DELAY, REPEAT: begin
            if (hold_ok) begin
               if (cnt_q == tc) begin
                  inc_d = ~dir_q;
                  dec_d = dir_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign set_mode   = lvl_q[0];
   assign btn1_level = lvl_q[1];
   assign btn2_level = lvl_q[2];
   assign inc_pulse  = inc_q;
   assign dec_pulse  = dec_q;

endmodule
